ysyx_23060203_div: RTL and testbench
====================================

// Module: ysyx_23060203_div
// PURPOSE
//  Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) beside the single-cycle ALU in EXU.
//  Accepts operands plus funct3 via valid/ready, runs a radix-2 restoring divider,
//  and returns one 32-bit result via valid/ready. EXU stalls on in_ready/out_valid.
// PARAMETERS
//  W         32  operand/result width; iteration count = W
//  FAST_SPC  1   1: div-by-zero and signed overflow finish without iterating
// PORTS
//  clock      in   1  clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  flush      in   1  abort in-flight op (pipeline redirect); sync
//  in_valid   in   1  request valid
//  in_ready   out  1  unit idle, can accept
//  in_a       in   W  dividend (rs1)
//  in_b       in   W  divisor (rs2)
//  in_funct   in   3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer takes result
//  out_val    out  W  quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; out_val=0. Internal regs cleared.
//  States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid&in_ready: latch funct, signs, |a|,|b|
//    (abs only for funct[0]=0), clear partial remainder, cnt=W-1 -> CALC.
//    FAST_SPC=1 and special case -> DONE directly with fixed result.
//   CALC: in_ready=0. Per cycle: rem' = {rem[W-2:0], q[W-1]}; trial = rem' - |b|;
//    trial>=0 (W+1-bit compare) -> rem=trial, shift in 1; else keep rem', shift 0.
//    cnt==0 -> DONE. Exactly W cycles in CALC.
//   DONE: out_valid=1, out_val stable; stays until out_ready -> IDLE.
//    No accept in same cycle as out handshake (in_ready=0 in DONE).
//  Latency: accept in cycle N -> out_valid from cycle N+W+1 (normal), N+1 (special).
//  Sign fixup (signed ops) applied entering DONE: quotient negated iff sign(a)^sign(b);
//   remainder takes sign of dividend. Unsigned ops: no fixup.
//  Special cases (RISC-V defined, regardless of FAST_SPC value, same results):
//   b==0: quotient = all ones; remainder = a.
//   DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
//  With FAST_SPC=0 special cases iterate normally; fixup must still yield above values.
//  Unknown funct (funct[2]=0): accepted, treated as DIVU; EXU never issues it.
//  flush: any state -> IDLE next cycle, out_valid=0, result discarded; flush has
//   priority over in_valid same cycle (no accept). flush in IDLE: no effect.
//  reset mid-CALC/DONE: same as reset values above; no partial result emitted.
//  Inputs sampled only at accept; in_a/in_b may change afterwards freely.
//  out_val held constant while out_valid=1 and out_ready=0.
// STRUCTURE
//  Shared params include: funct3 codes DIV/DIVU/REM/REMU, state encodings IDLE/CALC/DONE.
//  Sub-module ysyx_23060203_div_step: combinational one-iteration restoring stage
//   (in rem,q,divisor; out rem',q'); instantiated once, reused every CALC cycle.
//  Top holds FSM, cnt (clog2(W) bits), operand/sign regs, fixup and special-case mux.
// TESTING
//  DIVU 100/7, out_ready=1 -> out_val=14 at accept+33; REMU same -> 2.
//  DIV -7/2 (0xFFFF_FFF9,2) -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; REM 7/-2 -> 1.
//  DIV 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; FAST_SPC=1 -> out_valid at accept+1.
//  DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM -> 0; check both FAST_SPC values.
//  Backpressure: out_ready=0 for 10 cycles in DONE -> out_val stable, in_ready=0;
//   then out_ready=1 -> IDLE next cycle, in_ready=1.
//  flush at CALC cycle 5 and flush+in_valid together -> no out_valid, no accept;
//   reset during CALC -> outputs at reset values; next op 9/3 -> 3.

Source files
------------

// File: rtl/ysyx_23060203_div_pkg.sv
// Shared definitions for the RV32M divide unit: funct3 codes, FSM states and
// small funct3 decode helpers used by the datapath.
package ysyx_23060203_div_pkg;

  localparam logic [2:0] FUNCT_DIV  = 3'b100;
  localparam logic [2:0] FUNCT_DIVU = 3'b101;
  localparam logic [2:0] FUNCT_REM  = 3'b110;
  localparam logic [2:0] FUNCT_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Codes outside the M group (funct3[2]=0) behave exactly like DIVU.
  function automatic logic [2:0] norm_funct(input logic [2:0] funct);
    return funct[2] ? funct : FUNCT_DIVU;
  endfunction

  function automatic logic is_signed_op(input logic [2:0] funct);
    return (norm_funct(funct) == FUNCT_DIV) || (norm_funct(funct) == FUNCT_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] funct);
    return (norm_funct(funct) == FUNCT_REM) || (norm_funct(funct) == FUNCT_REMU);
  endfunction

endpackage

// File: rtl/ysyx_23060203_div_step.sv
// One radix-2 restoring-division iteration: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, keep the result if non-negative.
module ysyx_23060203_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // The shifted remainder can exceed W bits for large unsigned divisors, so the
  // trial subtraction is one bit wider and its MSB acts as the borrow.
  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    rem_sh = {rem_i, quo_i[W-1]};
    trial  = rem_sh - {1'b0, dvs_i};
    quo_o  = {quo_i[W-2:0], ~trial[W]};
    rem_o  = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/ysyx_23060203_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with valid/ready on both sides,
// one restoring step per cycle, sign fixup and RISC-V special-case results.
module ysyx_23060203_div
  import ysyx_23060203_div_pkg::*;
#(
  parameter int W        = 32,
  parameter bit FAST_SPC = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_funct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_val
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  INT_MIN  = {1'b1, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  res_q, res_d;
  logic          is_rem_q, is_rem_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          spc_q, spc_d;

  // Operand decode, only meaningful in the accept cycle.
  logic         op_signed, op_rem, a_neg, b_neg, div_zero, overflow, special;
  logic [W-1:0] a_abs, b_abs, spc_res;

  assign op_signed = is_signed_op(in_funct);
  assign op_rem    = is_rem_op(in_funct);
  assign a_neg     = op_signed & in_a[W-1];
  assign b_neg     = op_signed & in_b[W-1];
  assign a_abs     = a_neg ? -in_a : in_a;
  assign b_abs     = b_neg ? -in_b : in_b;
  assign div_zero  = (in_b == '0);
  assign overflow  = op_signed & (in_a == INT_MIN) & (&in_b);
  assign special   = div_zero | overflow;

  always_comb begin
    spc_res = '0;
    if (div_zero) spc_res = op_rem ? in_a : '1;
    else if (overflow) spc_res = op_rem ? '0 : INT_MIN;
  end

  logic [W-1:0] step_rem, step_quo, quo_fix, rem_fix;

  ysyx_23060203_div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign quo_fix = neg_quo_q ? -step_quo : step_quo;
  assign rem_fix = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    spc_d     = spc_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          rem_d     = '0;
          quo_d     = a_abs;
          dvs_d     = b_abs;
          cnt_d     = CNT_LAST;
          is_rem_d  = op_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          spc_d     = special;
          // Special results are parked in res_q now; the slow path keeps them.
          res_d     = spc_res;
          state_d   = (FAST_SPC && special) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!spc_q) res_d = is_rem_q ? rem_fix : quo_fix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      spc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      spc_q     <= spc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_val   = res_q;

endmodule

// File: tb/tb_ysyx_23060203_div.sv
// Self-checking bench for ysyx_23060203_div: a FAST_SPC=1 and a FAST_SPC=0
// instance, expected results queued at issue and compared at out_valid.
module tb_ysyx_23060203_div;
  import ysyx_23060203_div_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, flush, out_ready;
  logic         in_valid, s_in_valid;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_funct;
  logic         in_ready, out_valid, s_in_ready, s_out_valid;
  logic [W-1:0] out_val, s_out_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [W-1:0] exp_q[$];

  ysyx_23060203_div #(.W(W), .FAST_SPC(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val)
  );

  ysyx_23060203_div #(.W(W), .FAST_SPC(1'b0)) dut_slow (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct(in_funct),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_val(s_out_val)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic sgn, rem;
    sgn = f[2] & ~f[0];
    rem = f[2] & f[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input bit slow, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit spc;
    spc = (b == 0) || (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (spc && !slow) ? 1 : W + 1;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit slow, input logic [2:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    int guard = 0;
    while (!(slow ? s_in_ready : in_ready) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue: in_ready never asserted, got 0 required 1");
    end
    in_a = a;
    in_b = b;
    in_funct = f;
    if (slow) s_in_valid = 1'b1;
    else in_valid = 1'b1;
    if (push) exp_q.push_back(model(f, a, b));
    acc_cyc = cyc;
    @(negedge clock);
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_funct = 3'($urandom);
  endtask

  task automatic collect(input bit slow, input int lat_req, input string name);
    int guard = 0;
    int lat;
    logic [W-1:0] got, exp;
    while (!(slow ? s_out_valid : out_valid) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL %s: out_valid timeout, got 0 required 1", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    got = slow ? s_out_val : out_val;
    lat = cyc - acc_cyc;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out_val got %h required %h", name, got, exp);
    end
    if (lat_req > 0) begin
      checks++;
      if (lat !== lat_req) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, lat_req);
      end
    end
    @(negedge clock);
  endtask

  task automatic run(input bit slow, input logic [2:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input string name);
    issue(slow, f, a, b, 1'b1);
    collect(slow, exp_lat(slow, f, a, b), name);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== '0 ||
        s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_val !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b val=%h srdy=%b svld=%b sval=%h required 1 0 0",
               in_ready, out_valid, out_val, s_in_ready, s_out_valid, s_out_val);
    end
  endtask

  task automatic test_unsigned();
    run(0, FUNCT_DIVU, 100, 7, "divu_100_7");
    run(0, FUNCT_REMU, 100, 7, "remu_100_7");
    run(0, FUNCT_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
    run(0, FUNCT_REMU, 32'hFFFF_FFFF, 32'h8000_0001, "remu_big");
    run(0, 3'b000, 100, 7, "unknown_funct");
  endtask

  task automatic test_signed();
    run(0, FUNCT_DIV, 32'hFFFF_FFF9, 2, "div_m7_2");
    run(0, FUNCT_REM, 32'hFFFF_FFF9, 2, "rem_m7_2");
    run(0, FUNCT_REM, 7, 32'hFFFF_FFFE, "rem_7_m2");
    run(0, FUNCT_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "div_m100_m7");
    run(1, FUNCT_DIV, 32'hFFFF_FFF9, 2, "slow_div_m7_2");
  endtask

  task automatic test_special();
    for (int s = 0; s < 2; s++) begin
      run(s[0], FUNCT_DIV, 5, 0, "div_by_zero");
      run(s[0], FUNCT_REMU, 5, 0, "remu_by_zero");
      run(s[0], FUNCT_DIV, 32'hFFFF_FFFB, 0, "div_neg_by_zero");
      run(s[0], FUNCT_REM, 32'hFFFF_FFFB, 0, "rem_neg_by_zero");
      run(s[0], FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run(s[0], FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    bit ok = 1'b1;
    out_ready = 1'b0;
    issue(0, FUNCT_DIVU, 1000, 9, 1'b1);
    collect(0, W + 1, "bp_value");
    held = out_val;
    repeat (10) begin
      if (out_val !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: val=%h rdy=%b vld=%b required %h 0 1", out_val, in_ready, out_valid, held);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    bit ok = 1'b1;
    issue(0, FUNCT_DIV, 1234, 7, 1'b0);
    repeat (4) @(negedge clock);
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = 50;
    in_b = 5;
    in_funct = FUNCT_DIVU;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    repeat (40) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_no_output: out_valid or busy seen after flush, required idle");
    end
    out_ready = 1'b0;
    issue(0, FUNCT_DIVU, 9, 0, 1'b0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    issue(0, FUNCT_DIVU, 77, 5, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== '0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b val=%h required 1 0 0", in_ready, out_valid, out_val);
    end
    run(0, FUNCT_DIVU, 9, 3, "after_reset_9_3");
  endtask

  task automatic test_back_to_back();
    logic [2:0] funct_tbl[5];
    logic [2:0] f;
    logic [W-1:0] a, b;
    funct_tbl = '{FUNCT_DIV, FUNCT_DIVU, FUNCT_REM, FUNCT_REMU, 3'b010};
    for (int i = 0; i < 12; i++) begin
      f = funct_tbl[i % 5];
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom;
      if (i % 4 == 1) b = -b;
      run(i[0], f, a, b, "b2b_random");
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    in_funct = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
